// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and BCD value constants for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
  localparam int BCD_W = 32;
  localparam logic [BCD_W-1:0] BCD_ZERO = '0;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: counter/display bus of the stopwatch controller
//   tick, count            : from tick divider and BCD counter
//   cnt_en, cnt_clr        : to BCD counter
//   disp_value, running,
//   lap_active             : to display path
//   master = controller side, slave = counter/display side
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;
  logic tick;
  logic [BCD_W-1:0] count;
  logic cnt_en;
  logic cnt_clr;
  logic [BCD_W-1:0] disp_value;
  logic running;
  logic lap_active;
  modport master(input tick, count, output cnt_en, cnt_clr, disp_value, running, lap_active);
  modport slave(output tick, count, input cnt_en, cnt_clr, disp_value, running, lap_active);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and press-event output for one button
//   clk, rst (async active-low), btn (raw pin), press (one-clk pulse on accepted 0->1)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, lvl_q, lvl_d, arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Synchronizer resets to "pressed" so a button held through reset is
  // never seen as a fresh press; arm only once a released level is observed.
  always_comb begin
    cnt_d = (s2_q == lvl_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    lvl_d = (s2_q != lvl_q && cnt_q == LAST) ? s2_q : lvl_q;
    arm_d = arm_q | ~s2_q;
    press = arm_q & lvl_d & ~lvl_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b0;
      arm_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      arm_q <= arm_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce and start/pause/lap/clear sequencing for a BCD stopwatch counter
//   clk, rst (async active-low), btn_start, btn_lap (raw pins)
//   bus (stopwatch_ctrl_if.master): tick/count in; cnt_en/cnt_clr/disp_value/running/lap_active out
//   STOPWATCH_LAP_EN: enables the LAP state and frozen lap display
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_lap,
  stopwatch_ctrl_if.master bus
);
  state_t state_q, state_d;
  logic start_ev, lap_raw, lap_ev;
  logic cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d, running_q, running_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (.clk(clk), .rst(rst), .btn(btn_start), .press(start_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (.clk(clk), .rst(rst), .btn(btn_lap), .press(lap_raw));
  // start wins when both events land in the same clk
  assign lap_ev = lap_raw & ~start_ev;
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    case (state_q)
      IDLE:  if (start_ev) state_d = RUN;
`ifdef STOPWATCH_LAP_EN
      RUN:   state_d = start_ev ? PAUSE : lap_ev ? LAP : RUN;
`else
      RUN:   if (start_ev) state_d = PAUSE;
`endif
      LAP:   state_d = start_ev ? PAUSE : lap_ev ? RUN : LAP;
      PAUSE: begin
        state_d   = start_ev ? RUN : lap_ev ? IDLE : PAUSE;
        cnt_clr_d = ~start_ev & lap_ev;
      end
      default: state_d = IDLE;
    endcase
    cnt_en_d  = bus.tick & (state_q == RUN || state_q == LAP);
    running_d = state_d == RUN || state_d == LAP;
  end
`ifdef STOPWATCH_LAP_EN
  logic [BCD_W-1:0] lap_q, lap_d;
  logic lap_active_q, lap_active_d;
  always_comb begin
    lap_d        = (state_q == RUN && state_d == LAP) ? bus.count : lap_q;
    lap_active_d = state_d == LAP;
    disp_d       = lap_active_d ? lap_d : bus.count;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q        <= BCD_ZERO;
      lap_active_q <= 1'b0;
    end else begin
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
    end
  end
  assign bus.lap_active = lap_active_q;
`else
  assign disp_d = bus.count;
  assign bus.lap_active = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
      disp_q    <= BCD_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
      disp_q    <= disp_d;
    end
  end
  assign bus.cnt_en     = cnt_en_q;
  assign bus.cnt_clr    = cnt_clr_q;
  assign bus.running    = running_q;
  assign bus.disp_value = disp_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller that sequences the BCD stopwatch counter (8 BCD digits, HH:MM:SS.cc packed into 32 bits). It debounces the two front-panel push-buttons and runs the start/pause/lap/clear state machine. It drives the counter's increment enable and synchronous clear, and supplies the 32-bit value to the display path, either live or a frozen lap snapshot. It sits between the button pins and tick generator on one side and the counter and seven-segment driver on the other.

## Interface
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable clocks needed to accept a button level (10 ms at 50 MHz); must be ≥ 2.
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-low reset.
- `btn_start` in 1 — raw start/pause button, asynchronous, active-high.
- `btn_lap` in 1 — raw lap/clear button, asynchronous, active-high.
- `tick` in 1 — one-clk pulse per centisecond from the tick divider.
- `count` in 32 — live packed BCD value from the counter.
- `cnt_en` out 1 — one-clk increment pulse to the counter.
- `cnt_clr` out 1 — one-clk synchronous clear pulse to the counter.
- `disp_value` out 32 — value for the display.
- `running` out 1 — high in RUN or LAP.
- `lap_active` out 1 — high while the display is frozen.

## Operation
- Each button: 2-flop synchronizer, then a stability counter. The accepted level updates when the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive clks. Any bounce restarts the count. A press event is a 0→1 change of the accepted level. Releases generate no event.
- States: IDLE, RUN, PAUSE, LAP.
  - IDLE: start → RUN. Lap is ignored.
  - RUN: start → PAUSE. Lap → LAP and latches `count` into the lap register.
  - LAP: lap → RUN and releases the display. Start → PAUSE and releases the display.
  - PAUSE: start → RUN. Lap → IDLE and pulses `cnt_clr`.
- If both press events occur in the same clk, start wins and the lap event is discarded.
- `cnt_en`: in the clk after `tick`, when the state during the tick clk was RUN or LAP.
- `cnt_clr`: exactly one clk, on the PAUSE→IDLE transition. `cnt_en` is never high in the same clk as `cnt_clr`.
- `disp_value` shows the lap register in LAP and `count` in all other states.
- Counter wrap from 99:59:59.99 to 00:00:00.00 belongs to the counter. The controller stays in its current state across the wrap.

## Timing
- Reset values:
  - State IDLE.
  - `cnt_en`, `cnt_clr`, `running`, `lap_active` = 0.
  - `disp_value` = 0.
  - Lap register = 0.
  - Accepted button levels = 0.
  - Debounce counters = 0.
- Reset asserted mid-operation returns to all reset values immediately. A button held through reset release produces no press event until it has been released and pressed again.
- Press latency: a clean press raises the event `2 + DEBOUNCE_CYCLES` clks after the pin edge. The state changes on the next clk edge.
- `running`, `lap_active`, and `disp_value` selection are registered and change in the same clk as the state.
- The lap snapshot captures `count` as registered in the clk the LAP transition occurs.
- A `tick` in the clk of RUN→PAUSE still produces its `cnt_en`, because the state during the tick clk was RUN.
- A `tick` in the clk of PAUSE→RUN produces no `cnt_en`.

## Configuration
- `STOPWATCH_LAP_EN` defined: full behaviour as above.
- `STOPWATCH_LAP_EN` undefined:
  - No LAP state and no lap register.
  - Lap press in RUN is ignored.
  - Lap press in PAUSE still clears.
  - `lap_active` is tied to 0.
  - `disp_value` always equals `count`.

## Structure
- `stopwatch_pkg` holds:
  - The state enum (IDLE/RUN/PAUSE/LAP).
  - The BCD width constant (32).
  - The BCD zero constant.
- Sub-module `btn_debounce` (synchronizer, stability counter, press-event output) is instantiated twice. Its counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset and start: reset released, then a clean `btn_start` press → `running`=1 at 6 clks after the pin edge. Each later `tick` yields exactly one `cnt_en`, one clk later.
- Bounce rejection: `btn_start` toggled every 2 clks for 20 clks, then held low → no state change, `cnt_en` stays 0.
- Lap freeze: in RUN with `count`=32'h00001234, press lap → `lap_active`=1 and `disp_value`=32'h00001234 while `count` advances to 32'h00001240. A second lap press → `disp_value` tracks `count` again.
- Clear: RUN, start, lap → PAUSE then IDLE, a single-clk `cnt_clr`, `running`=0, and no `cnt_en` on subsequent ticks.
- Simultaneous presses: both buttons' events in the same clk while in RUN → PAUSE, `lap_active`=0, no lap latch.
- Reset mid-LAP: assert `rst` while in LAP with `btn_start` held → all outputs 0. After release, no start event occurs until the button is released and pressed again.
